// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and default geometry for the register-file dump reader.
// Defaults match the 64 x 16-bit register file.
package regfile_dump_reader_pkg;

  localparam int unsigned AddrWidth = 6;
  localparam int unsigned DataWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend,
    StFinish
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready word stream carrying dumped register-file contents.
// The dump reader is the master; the downstream sink is the slave.
interface regfile_dump_reader_if #(
  parameter int unsigned DataWidth = 16
);

  logic [DataWidth-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/regfile_dump_reader_checksum_acc.sv
// Running modulo-2**Width sum of words transferred during a dump.
// Only instantiated when REGFILE_DUMP_CHECKSUM_EN is defined.
module dump_checksum_acc #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             add_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] sum_d, sum_q;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a range of register-file addresses and streams each word out over valid/ready.
// Define REGFILE_DUMP_CHECKSUM_EN to add the checksum_o output and its accumulator.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned AddressWidth  = AddrWidth,
  parameter int unsigned RegisterWidth = DataWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [AddressWidth-1:0]  base_addr_i,
  input  logic [AddressWidth:0]    count_i,
  output logic [AddressWidth-1:0]  rf_addr_o,
  input  logic [RegisterWidth-1:0] rf_rdata_i,
  regfile_dump_reader_if.master    out_if,
  output logic                     busy_o,
`ifdef REGFILE_DUMP_CHECKSUM_EN
  output logic [RegisterWidth-1:0] checksum_o,
`endif
  output logic                     done_o
);

  dump_state_t               state_q;
  logic [AddressWidth-1:0]   rf_addr_q;
  logic [AddressWidth:0]     remaining_q;
  logic [RegisterWidth-1:0]  out_data_q;
  logic                      out_valid_q;
  logic                      out_last_q;
  logic                      busy_q;
  logic                      done_q;

  logic start_accept;
  logic xfer;
  logic load_word;

  always_comb begin
    start_accept = (state_q == StIdle) && start_i;
    xfer         = out_valid_q && out_if.ready;
    // rf_addr_q doubles as the dump pointer, so the async read already reflects it
    load_word    = (state_q == StFetch) ||
                   ((state_q == StSend) && xfer && (remaining_q != '0));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rf_addr_q   <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            rf_addr_q   <= base_addr_i;
            remaining_q <= count_i;
            busy_q      <= 1'b1;
            state_q     <= (count_i == '0) ? StFinish : StFetch;
          end
        end
        StFetch: begin
          state_q <= StSend;
        end
        StSend: begin
          if (xfer && (remaining_q == '0)) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= StFinish;
          end
        end
        StFinish: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (load_word) begin
        out_data_q  <= rf_rdata_i;
        out_valid_q <= 1'b1;
        out_last_q  <= (remaining_q == 1);
        rf_addr_q   <= rf_addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

  assign rf_addr_o    = rf_addr_q;
  assign out_if.data  = out_data_q;
  assign out_if.valid = out_valid_q;
  assign out_if.last  = out_last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  dump_checksum_acc #(
    .Width (RegisterWidth)
  ) u_checksum (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (start_accept),
    .add_i   (xfer),
    .data_i  (out_data_q),
    .sum_o   (checksum_o)
  );
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader against a preloaded 64 x 16 register-file model.
// Checksum checks are compiled in when REGFILE_DUMP_CHECKSUM_EN is defined.
module tb_regfile_dump_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  count;
  logic [5:0]  rf_addr;
  logic [15:0] rf_rdata;
  logic        busy;
  logic        done;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  logic [15:0] regs [64];

  regfile_dump_reader_if #(.DataWidth(16)) out_if ();

  regfile_dump_reader dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .count_i     (count),
    .rf_addr_o   (rf_addr),
    .rf_rdata_i  (rf_rdata),
    .out_if      (out_if),
    .busy_o      (busy),
`ifdef REGFILE_DUMP_CHECKSUM_EN
    .checksum_o  (checksum),
`endif
    .done_o      (done)
  );

  assign rf_rdata = regs[rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] got_q[$];
  logic        last_q[$];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a dump and samples every negedge until done, recording transferred words.
  task automatic run_dump(input string tag, input logic [5:0] base, input logic [6:0] cnt,
                          input bit stall);
    bit          seen_done = 0;
    bit          prev_stalled = 0;
    logic [15:0] prev_data = '0;
    int          first_valid = -1;
    int          first_xfer = -1;
    int          last_k = -1;
    int          done_k = -1;
    bit          rdy;
    got_q.delete();
    last_q.delete();
    @(negedge clk);
    start = 1'b1; base_addr = base; count = cnt;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    for (int k = 0; k < 400 && !seen_done; k++) begin
      rdy = stall ? (k % 3 == 0) : 1'b1;
      out_if.ready = rdy;
      if (prev_stalled) check({tag, "_hold"}, out_if.data, prev_data);
      if (out_if.valid && first_valid < 0) first_valid = k;
      if (done) begin
        seen_done = 1;
        done_k = k;
        check({tag, "_busy_at_done"}, busy, 0);
      end
      if (out_if.valid && rdy) begin
        if (first_xfer < 0) first_xfer = k;
        got_q.push_back(out_if.data);
        last_q.push_back(out_if.last);
        last_k = k;
      end
      prev_stalled = out_if.valid && !rdy;
      prev_data = out_if.data;
      if (!seen_done) @(negedge clk);
    end
    if (!seen_done) check({tag, "_done_timeout"}, 0, 1);
    check({tag, "_nwords"}, got_q.size(), cnt);
    if (cnt == 0) begin
      check({tag, "_done_lat0"}, done_k, 1);
    end else begin
      check({tag, "_first_valid"}, first_valid, 1);
      check({tag, "_done_lat"}, done_k - last_k, 2);
      if (!stall) check({tag, "_b2b"}, last_k - first_xfer, cnt - 1);
    end
    for (int i = 0; i < got_q.size(); i++)
      check($sformatf("%s_last%0d", tag, i), last_q[i], (i == got_q.size() - 1));
`ifdef REGFILE_DUMP_CHECKSUM_EN
    if (seen_done) check({tag, "_csum_zero_len"}, (cnt == 0) ? checksum : 0, 0);
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    out_if.ready = 1'b1;
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 16'hA000 + 16'(i);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_if.ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_data", out_if.data, 0);
    check("rst_valid", out_if.valid, 0);
    check("rst_last", out_if.last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    run_dump("t1", 6'd4, 7'd3, 1'b0);
    exp_q = '{16'hA004, 16'hA005, 16'hA006};
    check_words("t1");
    check("t1_rf_addr_hold", rf_addr, 7);

    run_dump("t2", 6'd62, 7'd4, 1'b0);
    exp_q = '{16'hA03E, 16'hA03F, 16'hA000, 16'hA001};
    check_words("t2");

    run_dump("t3", 6'd0, 7'd5, 1'b1);
    exp_q = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004};
    check_words("t3");

    run_dump("t4", 6'd9, 7'd0, 1'b0);

    // Restart attempt mid-dump, then reset during the second word.
    @(negedge clk);
    start = 1'b1; base_addr = 6'd8; count = 7'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t5_w0", out_if.data, 16'hA008);
    start = 1'b1; base_addr = 6'd0; count = 7'd2;
    @(negedge clk);
    start = 1'b0;
    check("t5_w1_restart_ignored", out_if.data, 16'hA009);
    check("t5_busy_mid", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_rf_addr", rf_addr, 0);
    check("t5_data", out_if.data, 0);
    check("t5_valid", out_if.valid, 0);
    check("t5_last", out_if.last, 0);
    check("t5_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_done", done, 0);
      @(negedge clk);
    end
    run_dump("t5b", 6'd20, 7'd2, 1'b0);
    exp_q = '{16'hA014, 16'hA015};
    check_words("t5b");

`ifdef REGFILE_DUMP_CHECKSUM_EN
    run_dump("t6", 6'd0, 7'd64, 1'b0);
    check("t6_first", got_q[0], 16'hA000);
    check("t6_final", got_q[63], 16'hA03F);
    check("t6_checksum", checksum, 16'h07E0);
    @(negedge clk);
    check("t6_checksum_stable", checksum, 16'h07E0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
